// File: rtl/serial_arith_pkg.sv
// serial_arith_pkg: shared state encoding and default width for the serial arithmetic cells
package serial_arith_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/full_add1bit.sv
// full_add1bit: single-bit combinational full adder cell
module full_add1bit (
    input  logic x,
    input  logic y,
    input  logic c_in,
    output logic s,
    output logic c_out
);

    assign s     = x ^ y ^ c_in;
    assign c_out = (x & y) | (x & c_in) | (y & c_in);

endmodule

// File: rtl/serial_adder.sv
// serial_adder: LSB-first bit-serial adder with valid/ready in and out; SERIAL_ADD_OVF_EN adds signed overflow output ovf
module serial_adder
    import serial_arith_pkg::*;
#(
    parameter  int WIDTH = DEFAULT_WIDTH,
    localparam int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout
`ifdef SERIAL_ADD_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    state_t           state;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] sum_sh;
    logic [WIDTH-1:0] sum_nx;
    logic             carry;
    logic [CNT_W-1:0] cnt;
    logic             s_bit;
    logic             c_bit;

    full_add1bit u_fa (
        .x     (a_sh[0]),
        .y     (b_sh[0]),
        .c_in  (carry),
        .s     (s_bit),
        .c_out (c_bit)
    );

    assign sum_nx    = (sum_sh >> 1) | (WIDTH'(s_bit) << (WIDTH - 1));
    assign in_ready  = state == ST_IDLE;
    assign out_valid = state == ST_DONE;

    // FSM: capture operands, shift one bit per cycle through the adder cell, hold the result until taken
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= ST_IDLE;
            a_sh   <= '0;
            b_sh   <= '0;
            sum_sh <= '0;
            carry  <= 1'b0;
            cnt    <= '0;
            sum    <= '0;
            cout   <= 1'b0;
`ifdef SERIAL_ADD_OVF_EN
            ovf    <= 1'b0;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        a_sh  <= a;
                        b_sh  <= b;
                        carry <= cin;
                        cnt   <= '0;
                        state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    a_sh   <= a_sh >> 1;
                    b_sh   <= b_sh >> 1;
                    sum_sh <= sum_nx;
                    carry  <= c_bit;
                    cnt    <= cnt + CNT_W'(1);
                    if (cnt == LAST) begin
                        sum   <= sum_nx;
                        cout  <= c_bit;
`ifdef SERIAL_ADD_OVF_EN
                        ovf   <= carry ^ c_bit;
`endif
                        state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (out_ready) state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder: randomized self-checking bench for serial_adder (WIDTH=8 and WIDTH=1 instances; honours SERIAL_ADD_OVF_EN)
module tb_serial_adder;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0, out_ready = 1'b1, cin = 1'b0;
    logic [7:0] a = '0, b = '0;
    logic       in_ready, out_valid, cout;
    logic [7:0] sum;
    logic       iv1 = 1'b0, or1 = 1'b1, a1 = 1'b0, b1 = 1'b0, cin1 = 1'b0;
    logic       ir1, ov1, s1, c1;
`ifdef SERIAL_ADD_OVF_EN
    logic       ovf, ovf1;
`endif

    int total = 0;
    int passed = 0;

    always #5 clk = ~clk;

    serial_adder #(.WIDTH(8)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .cin(cin), .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum), .cout(cout)
`ifdef SERIAL_ADD_OVF_EN
        , .ovf(ovf)
`endif
    );

    serial_adder #(.WIDTH(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv1), .in_ready(ir1),
        .a(a1), .b(b1), .cin(cin1), .out_valid(ov1), .out_ready(or1),
        .sum(s1), .cout(c1)
`ifdef SERIAL_ADD_OVF_EN
        , .ovf(ovf1)
`endif
    );

    // Reference: plain integer arithmetic, signed overflow from the signed interpretation of the operands
    function automatic void ref_add(input int w, input longint ua, input longint ub, input logic ci,
                                    output longint rs, output logic rc, output logic ro);
        longint m = longint'(1) << w;
        longint t = ua + ub + longint'(ci);
        longint sa = (ua >= m / 2) ? ua - m : ua;
        longint sb = (ub >= m / 2) ? ub - m : ub;
        longint ss = sa + sb + longint'(ci);
        rs = t % m;
        rc = t >= m;
        ro = (ss >= m / 2) || (ss < -(m / 2));
    endfunction

    task automatic run_op(input logic [7:0] ia, input logic [7:0] ib, input logic ic,
                          output int lat, output logic [7:0] rs, output logic rc, output logic ro,
                          output logic rdy_seen, output logic post_ov, output logic post_ir);
        a = ia; b = ib; cin = ic; in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 0;
        rdy_seen = 1'b0;
        while (out_valid !== 1'b1 && lat < 100) begin
            rdy_seen |= in_ready;
            @(posedge clk); #1;
            lat++;
        end
        rdy_seen |= in_ready;
        rs = sum;
        rc = cout;
`ifdef SERIAL_ADD_OVF_EN
        ro = ovf;
`else
        ro = 1'b0;
`endif
        @(posedge clk); #1;
        post_ov = out_valid;
        post_ir = in_ready;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        total++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready got=%b exp=1", in_ready); else passed++;
        total++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid got=%b exp=0", out_valid); else passed++;
        total++; if (sum !== 8'h00) $display("FAIL reset_sum got=%h exp=00", sum); else passed++;
        total++; if (cout !== 1'b0) $display("FAIL reset_cout got=%b exp=0", cout); else passed++;
        total++; if (ir1 !== 1'b1 || ov1 !== 1'b0) $display("FAIL reset_w1 got ir=%b ov=%b exp ir=1 ov=0", ir1, ov1); else passed++;
`ifdef SERIAL_ADD_OVF_EN
        total++; if (ovf !== 1'b0) $display("FAIL reset_ovf got=%b exp=0", ovf); else passed++;
`endif
    endtask

    task automatic check_op(input string name, input logic [7:0] ia, input logic [7:0] ib, input logic ic);
        int lat;
        logic [7:0] rs;
        logic rc, ro, rdy, pov, pir;
        longint es;
        logic ec, eo;
        ref_add(8, longint'(ia), longint'(ib), ic, es, ec, eo);
        run_op(ia, ib, ic, lat, rs, rc, ro, rdy, pov, pir);
        total++; if (lat != 8) $display("FAIL %s_latency got=%0d exp=8", name, lat); else passed++;
        total++; if (rs !== es[7:0] || rc !== ec) $display("FAIL %s_result %h+%h+%b got sum=%h cout=%b exp sum=%h cout=%b", name, ia, ib, ic, rs, rc, es[7:0], ec); else passed++;
        total++; if (rdy !== 1'b0) $display("FAIL %s_in_ready_busy got=%b exp=0", name, rdy); else passed++;
        total++; if (pov !== 1'b0 || pir !== 1'b1) $display("FAIL %s_after_handshake got ov=%b ir=%b exp ov=0 ir=1", name, pov, pir); else passed++;
`ifdef SERIAL_ADD_OVF_EN
        total++; if (ro !== eo) $display("FAIL %s_ovf got=%b exp=%b", name, ro, eo); else passed++;
`endif
    endtask

    task automatic test_directed;
        check_op("add_35_4a", 8'h35, 8'h4A, 1'b0);
        check_op("add_ff_01", 8'hFF, 8'h01, 1'b0);
        check_op("add_7f_01_c", 8'h7F, 8'h01, 1'b1);
    endtask

    task automatic test_random;
        for (int i = 0; i < 20; i++)
            check_op("rand", 8'($urandom), 8'($urandom), 1'($urandom));
    endtask

    task automatic test_backpressure;
        longint es;
        logic ec, eo;
        logic [7:0] hs;
        logic hc;
        int lat;
        ref_add(8, 64'h5C, 64'hA7, 1'b1, es, ec, eo);
        out_ready = 1'b0;
        a = 8'h5C; b = 8'hA7; cin = 1'b1; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        a = 8'h11; b = 8'h22; cin = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 2;
        while (out_valid !== 1'b1 && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        total++; if (lat != 8) $display("FAIL bp_latency got=%0d exp=8", lat); else passed++;
        hs = sum;
        hc = cout;
        total++; if (hs !== es[7:0] || hc !== ec) $display("FAIL bp_result got sum=%h cout=%b exp sum=%h cout=%b", hs, hc, es[7:0], ec); else passed++;
        for (int i = 0; i < 5; i++) begin
            in_valid = i[0];
            a = 8'h01; b = 8'h01;
            @(posedge clk); #1;
            total++; if (out_valid !== 1'b1 || in_ready !== 1'b0 || sum !== hs || cout !== hc)
                $display("FAIL bp_hold cyc=%0d got ov=%b ir=%b sum=%h cout=%b exp ov=1 ir=0 sum=%h cout=%b", i, out_valid, in_ready, sum, cout, hs, hc);
            else passed++;
        end
        in_valid = 1'b1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        total++; if (out_valid !== 1'b0 || in_ready !== 1'b1) $display("FAIL bp_release got ov=%b ir=%b exp ov=0 ir=1", out_valid, in_ready); else passed++;
        repeat (3) @(posedge clk);
        #1;
        total++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || sum !== hs) $display("FAIL bp_no_extra_op got ov=%b ir=%b sum=%h exp ov=0 ir=1 sum=%h", out_valid, in_ready, sum, hs); else passed++;
    endtask

    task automatic test_reset_mid_run;
        a = 8'hC3; b = 8'h5A; cin = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        total++; if (in_ready !== 1'b1 || out_valid !== 1'b0 || sum !== 8'h00 || cout !== 1'b0)
            $display("FAIL midrun_reset got ir=%b ov=%b sum=%h cout=%b exp ir=1 ov=0 sum=00 cout=0", in_ready, out_valid, sum, cout);
        else passed++;
        repeat (12) @(posedge clk);
        #1;
        total++; if (out_valid !== 1'b0) $display("FAIL midrun_no_result got ov=%b exp=0", out_valid); else passed++;
        check_op("after_reset", 8'h10, 8'h20, 1'b0);
    endtask

    task automatic test_width1;
        longint es;
        logic ec, eo;
        ref_add(1, 64'd1, 64'd1, 1'b1, es, ec, eo);
        a1 = 1'b1; b1 = 1'b1; cin1 = 1'b1; iv1 = 1'b1; or1 = 1'b1;
        @(posedge clk); #1;
        iv1 = 1'b0;
        total++; if (ir1 !== 1'b0 || ov1 !== 1'b0) $display("FAIL w1_run got ir=%b ov=%b exp ir=0 ov=0", ir1, ov1); else passed++;
        @(posedge clk); #1;
        total++; if (ov1 !== 1'b1) $display("FAIL w1_latency got ov=%b exp=1", ov1); else passed++;
        total++; if (s1 !== es[0] || c1 !== ec) $display("FAIL w1_result got sum=%b cout=%b exp sum=%b cout=%b", s1, c1, es[0], ec); else passed++;
`ifdef SERIAL_ADD_OVF_EN
        total++; if (ovf1 !== eo) $display("FAIL w1_ovf got=%b exp=%b", ovf1, eo); else passed++;
`endif
        @(posedge clk); #1;
        total++; if (ov1 !== 1'b0 || ir1 !== 1'b1) $display("FAIL w1_release got ov=%b ir=%b exp ov=0 ir=1", ov1, ir1); else passed++;
    endtask

    initial begin
        test_reset;
        test_directed;
        test_random;
        test_backpressure;
        test_reset_mid_run;
        test_width1;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/serial_adder.md
Name: serial_adder

Overview:
- Bit-serial N-bit adder: the addition-direction counterpart of the team's ripple subtract datapath.
- Accepts two WIDTH-bit operands plus carry-in over a valid/ready handshake.
- Adds LSB-first, one bit per clock, through a single 1-bit full-adder cell.
- Presents sum and carry-out over a second valid/ready handshake.
- Used wherever area matters more than latency; the ALU-lite path pairs it with the existing subtractor cells.

Parameters:
- WIDTH, default 8: operand and sum width in bits; legal range 1..32.
- CNT_W, default $clog2(WIDTH+1): bit-counter width; derived, not overridden.

Ports:
- clk  input  1  single clock, all state updates on rising edge.
- rst_n  input  1  reset; synchronous, active-low.
- in_valid  input  1  operands valid.
- in_ready  output  1  block can accept operands.
- a  input  WIDTH  operand A, sampled on input handshake.
- b  input  WIDTH  operand B, sampled on input handshake.
- cin  input  1  carry-in, sampled on input handshake.
- out_valid  output  1  sum and cout valid.
- out_ready  input  1  consumer accepts result.
- sum  output  WIDTH  a + b + cin, modulo 2^WIDTH.
- cout  output  1  carry out of bit WIDTH-1.
- ovf  output  1  signed overflow; present only with SERIAL_ADD_OVF_EN.

Behaviour:
- Reset (rst_n low at a rising edge):
  - State goes to IDLE.
  - in_ready=1, out_valid=0, sum=0, cout=0, ovf=0.
  - Shift registers, carry and counter are cleared.
  - Reset mid-RUN or in DONE aborts the operation; no result is emitted.
- State IDLE:
  - in_ready=1.
  - When in_valid&&in_ready: capture a, b into shift registers and cin into the carry flop, clear the counter, go to RUN.
- State RUN:
  - in_ready=0.
  - Each cycle the full adder takes a_sh[0], b_sh[0] and carry.
  - The sum bit shifts into sum_sh at MSB (shift right); a_sh and b_sh shift right; carry flop <= carry-out; counter increments.
  - When the counter reaches WIDTH-1 on a cycle: that cycle's bit is the last, go to DONE.
- State DONE:
  - out_valid=1; sum=sum_sh; cout=carry flop.
  - Outputs are held stable until out_valid&&out_ready.
  - On that handshake, go to IDLE; out_valid drops next cycle.
- Latency:
  - out_valid rises exactly WIDTH rising edges after the accepting edge.
  - Throughput is one operation per WIDTH+2 cycles with out_ready held high.
- No overlap:
  - in_ready=0 in RUN and DONE.
  - in_valid during those states is ignored; operands are not stored.
  - in_valid and out_ready both high in DONE: only the output handshake completes; in_ready=1 the following cycle.
- out_ready is ignored outside DONE.
- WIDTH=1: RUN lasts exactly one cycle.
- Arithmetic is unsigned modulo 2^WIDTH. Wrap is visible only through cout, e.g. all-ones + 1 gives sum 0, cout 1.
- sum and cout are registered outputs; they hold the last result in IDLE until the next DONE updates them.

Optional Feature:
- Macro: SERIAL_ADD_OVF_EN.
- Defined:
  - Adds output ovf.
  - Captures the carry into the MSB (carry flop value entering the last RUN cycle).
  - ovf = carry_into_msb XOR cout, valid with out_valid, held with sum; reset 0.
- Undefined:
  - Port ovf and its flop are absent.
  - All other behaviour is identical.

Decomposition:
- Shared package serial_arith_pkg:
  - State encoding localparams ST_IDLE=2'd0, ST_RUN=2'd1, ST_DONE=2'd2; 2'd3 is illegal and recovers to IDLE.
  - Default WIDTH constant.
- Sub-module full_add1bit (x, y, c_in, s, c_out):
  - Purely combinational.
  - s = x^y^c_in; c_out = majority(x, y, c_in).
  - Instantiated once.
- Top holds the FSM, counter, shift registers and output registers.

Test Plan:
- Reset, then 8'h35 + 8'h4A, cin=0, out_ready=1 -> out_valid 8 edges after accept; sum=8'h7F, cout=0; in_ready low throughout.
- 8'hFF + 8'h01, cin=0 -> sum=8'h00, cout=1; with SERIAL_ADD_OVF_EN, ovf=0.
- 8'h7F + 8'h01, cin=1 -> sum=8'h81, cout=0; with SERIAL_ADD_OVF_EN, ovf=1.
- Backpressure: out_ready low 5 cycles in DONE, with in_valid pulsed during RUN and DONE -> sum and cout stable; the extra operands are never accepted; in_ready rises 1 cycle after the out handshake.
- rst_n low for one edge at bit 3 of RUN -> next cycle IDLE; out_valid=0, sum=0, cout=0; the following 8'h10 + 8'h20 gives 8'h30.
- WIDTH=1 build: a=1, b=1, cin=1 -> out_valid 1 edge after accept; sum=1, cout=1.
